// File: rtl/count_seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_seg7_pkg
// Brief    : Shared scan-state encoding and 7-segment patterns for the
//            counter display.
// Revision : 1.0 - initial release
// ============================================================================
package count_seg7_pkg;

    typedef enum logic [1:0] {
        ONES = 2'd0,
        GAP1 = 2'd1,
        TENS = 2'd2,
        GAP2 = 2'd3
    } scan_state_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_DARK = 7'h00;

endpackage : count_seg7_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : Combinational decimal digit to active-high 7-segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import count_seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_pattern
);

    // Non-decimal codes cannot occur here; they decode to dark for safety.
    always_comb begin
        o_pattern = SEG_DARK;
        if (i_digit <= 4'd9) begin
            o_pattern = SEG7_LUT[i_digit];
        end
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/count_seg7_display.sv
`default_nettype none
// ============================================================================
// Module   : count_seg7_display
// Brief    : Resynchronises and filters a slow 4-bit count, then scans it onto
//            a two-digit multiplexed 7-segment display with blank gaps.
// Revision : 1.0 - initial release
// ============================================================================
module count_seg7_display
    import count_seg7_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int GAP_CYCLES     = 500,
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic [3:0] shown,
    output logic       update_pulse
);

    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int MAX_LIM = (DIV > GAP_CYCLES) ? DIV : GAP_CYCLES;
    localparam int PW      = $clog2(MAX_LIM);

    localparam logic [PW-1:0] c_div_last = PW'(DIV - 1);
    localparam logic [PW-1:0] c_gap_last = PW'(GAP_CYCLES - 1);
    localparam logic [6:0]    c_seg_off  = SEG_ACTIVE_LOW ? ~SEG_DARK : SEG_DARK;
    localparam logic [1:0]    c_an_off   = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

    generate
        if (DIV < 2) begin : g_div_check
            $error("count_seg7_display: CLK_HZ/SCAN_HZ must be at least 2");
        end
        if (GAP_CYCLES < 1) begin : g_gap_check
            $error("count_seg7_display: GAP_CYCLES must be at least 1");
        end
    endgenerate

    logic [3:0]    r_s1, r_s2, r_s3, r_shown;
    logic          r_update;
    scan_state_t   r_state, w_state_next;
    logic [PW-1:0] r_presc;
    logic          w_last;
    logic          w_tens_nz;
    logic [3:0]    w_ones, w_digit;
    logic          w_lit;
    logic [1:0]    w_an_hi;
    logic [6:0]    w_pattern, w_seg_hi;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    // Three-stage resync; a value is accepted only once s2 and s3 agree.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_s1     <= 4'd0;
            r_s2     <= 4'd0;
            r_s3     <= 4'd0;
            r_shown  <= 4'd0;
            r_update <= 1'b0;
        end else begin
            r_s1     <= count;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_update <= 1'b0;
            if ((r_s2 == r_s3) && (r_s2 != r_shown)) begin
                r_shown  <= r_s2;
                r_update <= 1'b1;
            end
        end
    end

    assign w_tens_nz = (r_shown >= 4'd10);
    assign w_ones    = w_tens_nz ? (r_shown - 4'd10) : r_shown;

    always_comb begin
        w_state_next = r_state;
        if ((r_state == ONES) || (r_state == TENS)) begin
            w_last = (r_presc == c_div_last);
        end else begin
            w_last = (r_presc == c_gap_last);
        end
        if (w_last) begin
            case (r_state)
                ONES:    w_state_next = GAP1;
                GAP1:    w_state_next = TENS;
                TENS:    w_state_next = GAP2;
                GAP2:    w_state_next = ONES;
                default: w_state_next = ONES;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_state <= ONES;
            r_presc <= '0;
        end else if (w_last) begin
            r_state <= w_state_next;
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_comb begin
        w_an_hi = 2'b00;
        w_digit = 4'd0;
        w_lit   = 1'b0;
        case (r_state)
            ONES: begin
                w_an_hi = 2'b01;
                w_digit = w_ones;
                w_lit   = 1'b1;
            end
            TENS: begin
                if (!(BLANK_LEADING && !w_tens_nz)) begin
                    w_an_hi = 2'b10;
                    w_digit = {3'b000, w_tens_nz};
                    w_lit   = 1'b1;
                end
            end
            default: ;
        endcase
        if (blank) begin
            w_an_hi = 2'b00;
            w_lit   = 1'b0;
        end
    end

    seg7_decode u_decode (
        .i_digit   (w_digit),
        .o_pattern (w_pattern)
    );

    assign w_seg_hi = w_lit ? w_pattern : SEG_DARK;

    // Segments and anodes share one register so an enabled digit never sees stale segments.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_seg <= c_seg_off;
            r_an  <= c_an_off;
        end else begin
            r_seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
            r_an  <= AN_ACTIVE_LOW ? ~w_an_hi : w_an_hi;
        end
    end

    assign seg          = r_seg;
    assign an           = r_an;
    assign dp           = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    assign shown        = r_shown;
    assign update_pulse = r_update;

endmodule : count_seg7_display
`default_nettype wire

// File: tb/tb_count_seg7_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_seg7_display
// Brief    : Self-checking bench for count_seg7_display against a cycle-level
//            behavioural model of filtering and scan timing.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_count_seg7_display;

    localparam int DIV    = 10;
    localparam int GAP    = 2;
    localparam int PERIOD = 2 * DIV + 2 * GAP;

    logic       clk_50mhz = 1'b0;
    logic       rst, blank;
    logic [3:0] count;
    logic [6:0] seg, seg_nb;
    logic       dp, dp_nb;
    logic [1:0] an, an_nb;
    logic [3:0] shown, shown_nb;
    logic       update_pulse, update_pulse_nb;

    int n_checks = 0;
    int n_errors = 0;

    int         m_phase, m_shown, m_h1, m_h2, m_h3;
    logic       m_pulse;
    logic [6:0] m_seg, m_seg_nb;
    logic [1:0] m_an, m_an_nb;

    always #5 clk_50mhz = ~clk_50mhz;

    count_seg7_display #(
        .CLK_HZ(1000), .SCAN_HZ(100), .GAP_CYCLES(GAP), .BLANK_LEADING(1'b1),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .count(count), .blank(blank),
        .seg(seg), .dp(dp), .an(an), .shown(shown), .update_pulse(update_pulse)
    );

    count_seg7_display #(
        .CLK_HZ(1000), .SCAN_HZ(100), .GAP_CYCLES(GAP), .BLANK_LEADING(1'b0),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_nb (
        .clk_50mhz(clk_50mhz), .rst(rst), .count(count), .blank(blank),
        .seg(seg_nb), .dp(dp_nb), .an(an_nb), .shown(shown_nb),
        .update_pulse(update_pulse_nb)
    );

    a_an_onehot : assert property (@(negedge clk_50mhz) $onehot0(~an) && $onehot0(~an_nb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] lut(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Display content for the scan phase before the edge, as active-low levels.
    task automatic expected_out(input bit lead_blank, output logic [6:0] s, output logic [1:0] a);
        logic [6:0] hi;
        logic [1:0] ah;
        hi = 7'h00;
        ah = 2'b00;
        if (!blank) begin
            if (m_phase < DIV) begin
                ah = 2'b01;
                hi = lut(m_shown % 10);
            end else if (m_phase >= DIV + GAP && m_phase < 2 * DIV + GAP) begin
                if (!(lead_blank && (m_shown / 10) == 0)) begin
                    ah = 2'b10;
                    hi = lut(m_shown / 10);
                end
            end
        end
        s = ~hi;
        a = ~ah;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_phase = 0;  m_shown = 0;  m_pulse = 1'b0;
            m_h1 = 0;     m_h2 = 0;     m_h3 = 0;
            m_seg = 7'h7F;  m_an = 2'b11;  m_seg_nb = 7'h7F;  m_an_nb = 2'b11;
        end else begin
            expected_out(1'b1, m_seg, m_an);
            expected_out(1'b0, m_seg_nb, m_an_nb);
            m_phase = (m_phase + 1) % PERIOD;
            m_pulse = 1'b0;
            if (m_h2 == m_h3 && m_h2 != m_shown) begin
                m_shown = m_h2;
                m_pulse = 1'b1;
            end
            m_h3 = m_h2;
            m_h2 = m_h1;
            m_h1 = int'(count);
        end
    endtask

    task automatic step();
        @(posedge clk_50mhz);
        model_edge();
        @(negedge clk_50mhz);
        check("seg", 32'(seg), 32'(m_seg));
        check("an", 32'(an), 32'(m_an));
        check("shown", 32'(shown), 32'(m_shown));
        check("update_pulse", 32'(update_pulse), 32'(m_pulse));
        check("dp", 32'(dp), 32'd1);
        check("seg_noblank", 32'(seg_nb), 32'(m_seg_nb));
        check("an_noblank", 32'(an_nb), 32'(m_an_nb));
        check("shown_noblank", 32'(shown_nb), 32'(m_shown));
        check("an_onehot", 32'($onehot0(~an)), 32'd1);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        logic [3:0] prev;
        int         kind;
        rst = 1'b1;  count = 4'd7;  blank = 1'b0;
        run(3);
        rst = 1'b0;
        run(30);
        count = 4'd13;  run(60);
        count = 4'd5;   run(60);
        count = 4'd3;   run(10);
        count = 4'd9;   run(1);
        count = 4'd3;   run(10);
        count = 4'd9;   run(6);
        count = 4'd15;  run(10);
        count = 4'd0;   run(50);
        count = 4'd12;  run(10);
        for (int i = 0; i < PERIOD && m_phase != DIV + GAP; i++) step();
        blank = 1'b1;   run(30);
        blank = 1'b0;   run(30);
        for (int i = 0; i < PERIOD && m_phase != 5; i++) step();
        rst = 1'b1;     run(1);
        rst = 1'b0;     run(30);

        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) begin
                count = 4'($urandom_range(0, 15));
                run(int'($urandom_range(1, 30)));
            end else if (kind == 6) begin
                prev  = count;
                count = 4'($urandom_range(0, 15));
                run(1);
                count = prev;
                run(int'($urandom_range(1, 10)));
            end else if (kind == 7) begin
                blank = 1'b1;
                run(int'($urandom_range(1, 40)));
                blank = 1'b0;
            end else if (kind == 8) begin
                rst = 1'b1;
                run(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end else begin
                count = count + 4'd1;
                run(int'($urandom_range(3, 20)));
            end
        end
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_count_seg7_display
`default_nettype wire
